// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encoding, opcode constants and div decode helper
//            for the pipeline sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_FLUSH = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DIV_DONE = 2'd3
    } pipe_state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    function automatic logic is_div(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) && (funct == FUNCT_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_div_counter.sv
`default_nettype none
// ============================================================================
// Module   : div_cycle_counter
// Brief    : Loadable non-wrapping down-counter that times the divider's
//            busy window; reports when it has reached zero.
// Revision : 1.0 - initial release
// ============================================================================
module div_cycle_counter #(
    parameter int DIV_CYCLES = 32
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= C_LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for PC, IF/ID and ID/EX: branch squash and
//            iterative-divide freeze. Optional counters: PIPE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [5:0]  EX_OpCode,
    input  logic [5:0]  EX_Funct,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        FlushRegisters,
    output logic        Div_Start,
    output logic        Div_Busy,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count
);

    pipe_state_t r_state;
    pipe_state_t w_next_state;
    logic        w_load;
    logic        w_dec;
    logic        w_cnt_zero;
    logic        w_ex_is_div;

    assign w_ex_is_div = is_div(EX_OpCode, EX_Funct);
    assign w_dec       = (r_state == ST_DIV_WAIT);

    div_cycle_counter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_cycle_counter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .o_zero  (w_cnt_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_RUN, ST_DIV_DONE: begin
                if (EX_BranchTaken) begin
                    w_next_state = ST_BR_FLUSH;
                end else if (w_ex_is_div) begin
                    w_next_state = ST_DIV_WAIT;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_BR_FLUSH: w_next_state = ST_RUN;
            ST_DIV_WAIT: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DIV_DONE;
                end
            end
            default:     w_next_state = ST_RUN;
        endcase
    end

    // Outputs are flops decoded from the next state so they land on the same
    // edge as the state itself and reset asynchronously with it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_RUN;
            PCWrite        <= 1'b1;
            IF_ID_Write    <= 1'b1;
            ID_EX_Write    <= 1'b1;
            IF_ID_Flush    <= 1'b0;
            FlushRegisters <= 1'b0;
            Div_Start      <= 1'b0;
            Div_Busy       <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            PCWrite        <= (w_next_state != ST_DIV_WAIT);
            IF_ID_Write    <= (w_next_state != ST_DIV_WAIT);
            ID_EX_Write    <= (w_next_state != ST_DIV_WAIT);
            IF_ID_Flush    <= (w_next_state == ST_BR_FLUSH);
            FlushRegisters <= (w_next_state == ST_BR_FLUSH);
            Div_Start      <= w_load;
            Div_Busy       <= (w_next_state == ST_DIV_WAIT);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (r_state == ST_DIV_WAIT) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_next_state == ST_BR_FLUSH) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign Stall_Count = r_stall_count;
    assign Flush_Count = r_flush_count;
`else
    assign Stall_Count = 32'd0;
    assign Flush_Count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl with DIV_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int DIVC = 4;
    localparam int M_RUN = 0, M_BR = 1, M_WAIT = 2, M_DONE = 3;
    localparam logic [5:0] T_RTYPE = 6'b000000, T_ADDI = 6'b001000;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101;
    localparam logic [5:0] T_DIV = 6'b011010, T_ADD = 6'b100000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [5:0]  EX_OpCode = 6'd0;
    logic [5:0]  EX_Funct = 6'd0;
    logic        EX_BranchTaken = 1'b0;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
    logic        FlushRegisters, Div_Start, Div_Busy;
    logic [31:0] Stall_Count, Flush_Count;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .EX_OpCode      (EX_OpCode),
        .EX_Funct       (EX_Funct),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Write    (ID_EX_Write),
        .FlushRegisters (FlushRegisters),
        .Div_Start      (Div_Start),
        .Div_Busy       (Div_Busy),
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_st = M_RUN;
    int          m_rem = 0;
    bit          m_start = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, FlushRegisters, Div_Start, Div_Busy}
    function automatic logic [6:0] ctrl_of(input int st, input bit start);
        case (st)
            M_WAIT:  return {5'b00000, start, 1'b1};
            M_BR:    return 7'b1111100;
            default: return 7'b1110000;
        endcase
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, FlushRegisters, Div_Start, Div_Busy};
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef PIPE_CTRL_PERF_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush();
`ifdef PIPE_CTRL_PERF_EN
        return m_flush;
`else
        return 32'd0;
`endif
    endfunction

    // Drive one EX instruction for the next posedge, predict, then compare.
    task automatic cycle(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic br);
        exp_t e;
        @(negedge Clk);
        EX_OpCode      = op;
        EX_Funct       = fn;
        EX_BranchTaken = br;
        m_start = 1'b0;
        case (m_st)
            M_RUN, M_DONE: begin
                if (br) begin
                    m_st = M_BR;
                    m_flush++;
                end else if (op == T_RTYPE && fn == T_DIV) begin
                    m_st = M_WAIT;
                    m_rem = DIVC;
                    m_start = 1'b1;
                end else begin
                    m_st = M_RUN;
                end
            end
            M_BR: m_st = M_RUN;
            default: begin
                m_stall++;
                m_rem--;
                if (m_rem == 0) m_st = M_DONE;
            end
        endcase
        e.tag   = tag;
        e.ctrl  = ctrl_of(m_st, m_start);
        e.stall = exp_stall();
        e.flush = exp_flush();
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".ctrl"}, {25'd0, dut_ctrl()}, {25'd0, e.ctrl});
        check({e.tag, ".stall"}, Stall_Count, e.stall);
        check({e.tag, ".flush"}, Flush_Count, e.flush);
    endtask

    // Assert reset mid-cycle: outputs must return to RUN values with no clock.
    task automatic do_reset(input string tag);
        @(negedge Clk);
        EX_OpCode = T_ADDI; EX_Funct = 6'd0; EX_BranchTaken = 1'b0;
        Reset_n = 1'b0;
        #1;
        check({tag, ".async_ctrl"}, {25'd0, dut_ctrl()}, {25'd0, 7'b1110000});
        check({tag, ".async_stall"}, Stall_Count, 32'd0);
        check({tag, ".async_flush"}, Flush_Count, 32'd0);
        m_st = M_RUN; m_rem = 0; m_start = 1'b0; m_stall = 0; m_flush = 0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check({tag, ".rel_ctrl"}, {25'd0, dut_ctrl()}, {25'd0, 7'b1110000});
    endtask

    initial begin
        do_reset("reset");
        cycle("idle", T_ADDI, 6'd0, 1'b0);
        cycle("radd", T_RTYPE, T_ADD, 1'b0);

        // taken branch: one squash cycle, EX ignored while flushing
        cycle("beq_nt", T_BEQ, 6'd0, 1'b0);
        cycle("beq_t", T_BEQ, 6'd0, 1'b1);
        cycle("br_ign", T_RTYPE, T_DIV, 1'b1);
        cycle("br_after", T_ADDI, 6'd0, 1'b0);

        // single divide
        do_reset("rst_div");
        cycle("div_in", T_RTYPE, T_DIV, 1'b0);
        for (int i = 0; i < DIVC; i++) cycle("div_hold", T_RTYPE, T_DIV, 1'b0);
        cycle("div_next", T_ADDI, 6'd0, 1'b0);
        cycle("div_run", T_ADDI, 6'd0, 1'b0);

        // back-to-back divides
        do_reset("rst_b2b");
        cycle("b2b_in", T_RTYPE, T_DIV, 1'b0);
        for (int i = 0; i < DIVC; i++) cycle("b2b_hold1", T_RTYPE, T_DIV, 1'b0);
        cycle("b2b_second", T_RTYPE, T_DIV, 1'b0);
        for (int i = 0; i < DIVC; i++) cycle("b2b_hold2", T_RTYPE, T_DIV, 1'b0);
        cycle("b2b_done_br", T_BNE, 6'd0, 1'b1);
        cycle("b2b_run", T_ADDI, 6'd0, 1'b0);

        // reset during the second DIV_WAIT cycle
        do_reset("rst_mid");
        cycle("mid_in", T_RTYPE, T_DIV, 1'b0);
        cycle("mid_w2", T_RTYPE, T_DIV, 1'b0);
        do_reset("mid_reset");
        cycle("mid_after", T_ADDI, 6'd0, 1'b0);

        // branch has priority over div in the same cycle
        cycle("prio", T_RTYPE, T_DIV, 1'b1);
        cycle("prio_after", T_ADDI, 6'd0, 1'b0);
        cycle("prio_run", T_ADDI, 6'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 4-stage MIPS core. It owns the stall and flush controls for the PC, the IF/ID register and the ID/EX register. It sequences three cases: normal flow, a one-cycle squash after a taken beq/bne resolves in EX, and a multi-cycle freeze while the iterative divider runs a `div` held in EX. It sits beside the ID/EX register and drives that register's `FlushRegisters` input plus a new write-enable.

## Interface
- `DIV_CYCLES`, default 32: divider busy cycles per `div`; legal range is 2 to 64.
- `Clk` in 1: pipeline clock. State updates on posedge; the ID/EX register captures on negedge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `EX_OpCode` in 6: opcode of the instruction currently in EX (ID/EX output).
- `EX_Funct` in 6: funct field of the instruction currently in EX (ID/EX sign-extend output, bits [5:0]).
- `EX_BranchTaken` in 1: beq/bne in EX resolved taken (ALU zero combined with branch type).
- `PCWrite` out 1: PC load enable.
- `IF_ID_Write` out 1: IF/ID load enable.
- `IF_ID_Flush` out 1: IF/ID clears to NOP.
- `ID_EX_Write` out 1: ID/EX load enable; 0 holds its current contents.
- `FlushRegisters` out 1: ID/EX clears to zero.
- `Div_Start` out 1: one-cycle start pulse to the divider.
- `Div_Busy` out 1: the divider is in progress.
- `Stall_Count` out 32: cycles with `PCWrite` = 0 (see Configuration).
- `Flush_Count` out 32: number of branch squashes (see Configuration).

## Operation
- `div` detection: `EX_IsDiv` = (`EX_OpCode` == 6'b000000) and (`EX_Funct` == 6'b011010).
- State machine: RUN, BR_FLUSH, DIV_WAIT, DIV_DONE. All outputs are registered Moore decodes of the state.
- Output values per state:
  - RUN: all write enables = 1; flushes = 0; `Div_Start` = 0; `Div_Busy` = 0.
  - BR_FLUSH: write enables = 1; `IF_ID_Flush` = 1; `FlushRegisters` = 1.
  - DIV_WAIT: `PCWrite` = `IF_ID_Write` = `ID_EX_Write` = 0; `Div_Busy` = 1; `Div_Start` = 1 in the first DIV_WAIT cycle only.
  - DIV_DONE: same as RUN. The divider result is written during this cycle.
- Transitions from RUN and from DIV_DONE (same rules):
  - `EX_BranchTaken` → BR_FLUSH. This has priority over `EX_IsDiv`.
  - else `EX_IsDiv` → DIV_WAIT, with the down-counter loaded to `DIV_CYCLES`-1.
  - else → RUN.
- BR_FLUSH → RUN unconditionally. EX inputs are ignored in BR_FLUSH.
- DIV_WAIT: the counter decrements each cycle. When the counter reaches 0, the next state is DIV_DONE. EX inputs are ignored in DIV_WAIT.
- Counter width is $clog2(`DIV_CYCLES`). The counter never wraps; it loads only on entry to DIV_WAIT.

## Timing
- Reset (`Reset_n` low, asynchronous): state RUN, counter 0.
  - `PCWrite` = `IF_ID_Write` = `ID_EX_Write` = 1.
  - `IF_ID_Flush` = `FlushRegisters` = `Div_Start` = `Div_Busy` = 0.
  - `Stall_Count` = `Flush_Count` = 0.
- Reset mid-divide or mid-flush returns to RUN immediately. `Div_Busy` drops without waiting for a clock.
- EX inputs are sampled at posedge. They reflect the instruction the ID/EX register captured at the preceding negedge.
- Output latency: 1 posedge after the sampling edge. Outputs are stable half a cycle before the ID/EX negedge capture.
- Branch: `FlushRegisters` and `IF_ID_Flush` are high for exactly 1 cycle per taken branch.
- Divide: `Div_Busy` is high for exactly `DIV_CYCLES` cycles, followed by 1 DIV_DONE cycle.
- Back-to-back `div`: a second `div` captured into EX during DIV_DONE is detected at the DIV_DONE exit edge. It re-enters DIV_WAIT with no RUN cycle in between.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `Stall_Count` increments every cycle in DIV_WAIT.
  - `Flush_Count` increments on each entry to BR_FLUSH.
  - Both counters are 32-bit, wrap modulo 2^32, and clear on reset.
- `PIPE_CTRL_PERF_EN` undefined: no counter flops are built; both ports are tied to 32'd0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding (2-bit enum);
  - opcode constants `OP_RTYPE` = 6'b000000, `OP_ADDI` = 6'b001000, `OP_BEQ` = 6'b000100, `OP_BNE` = 6'b000101;
  - `FUNCT_DIV` = 6'b011010.
- One sub-module: `div_cycle_counter` (load, decrement, zero flag), parameterised by `DIV_CYCLES`.

## Test plan
- Reset check: hold `Reset_n` = 0 for 3 cycles, then release → RUN outputs, `Div_Busy` = 0, both counts 0.
- Taken branch: `EX_OpCode` = 000100 with `EX_BranchTaken` = 1 for one cycle → `FlushRegisters` = `IF_ID_Flush` = 1 for exactly 1 cycle; `Flush_Count` = 1 with `PIPE_CTRL_PERF_EN`.
- Single divide: `EX_OpCode` = 000000 with `EX_Funct` = 011010, `DIV_CYCLES` = 4 → `Div_Start` for 1 cycle, `Div_Busy` and all write enables at 0 for 4 cycles, 1 DIV_DONE cycle, `Stall_Count` = 4.
- Back-to-back divides: two consecutive `div` instructions, `DIV_CYCLES` = 4 → two DIV_WAIT windows separated by exactly one DIV_DONE cycle; `Stall_Count` = 8.
- Reset mid-divide: assert `Reset_n` = 0 in the 2nd DIV_WAIT cycle → `Div_Busy` = 0 and `PCWrite` = 1 asynchronously; state is RUN after release.
- Priority: `EX_BranchTaken` = 1 and `EX_IsDiv` = 1 in the same cycle → BR_FLUSH is taken, no `Div_Start`; without `PIPE_CTRL_PERF_EN`, both count ports read 0.
